// File: rtl/multicycle_cu.sv
// Multi-cycle main control unit for the MIPS datapath.
// Moore FSM that walks each instruction through fetch, decode and a short
// execute/memory/write-back tail, with a memory-ready handshake, an optional
// memory-wait timeout and sticky trap flags for illegal opcodes and timeouts.
module multicycle_cu #(
  parameter int MEM_WAIT_EN = 1,
  parameter int MEM_TIMEOUT = 0,
  parameter int SUPPORT_J   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // The timeout fires on the last allowed not-ready cycle, i.e. when the
  // counter already holds MEM_TIMEOUT-1 and memory is still not ready.
  localparam bit         TIMEOUT_EN   = (MEM_TIMEOUT > 0);
  localparam logic [7:0] TIMEOUT_LAST = (MEM_TIMEOUT > 0) ? 8'(MEM_TIMEOUT - 1) : 8'd0;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_waitCnt;
  logic       r_illegalOp;
  logic       r_memTimeout;
  logic       w_go;
  logic       w_memWait;
  logic       w_timeoutHit;
  logic       w_setIllegal;
  logic       w_setTimeout;

  // Memory completes either on mem_ready or unconditionally when waiting is disabled.
  assign w_go = mem_ready || (MEM_WAIT_EN == 0);

  // A memory state that is stalled this cycle; these cycles feed the timeout counter.
  assign w_memWait = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR)) && !w_go;

  // Timeout only counts when memory is still not ready, so a same-cycle mem_ready wins.
  assign w_timeoutHit = TIMEOUT_EN && w_memWait && (r_waitCnt == TIMEOUT_LAST);

  // Next-state decode, including opcode dispatch and trap entry.
  always_comb begin
    w_nextState  = r_state;
    w_setIllegal = 1'b0;
    w_setTimeout = 1'b0;
    case (r_state)
      S_FETCH:  if (w_go) w_nextState = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: w_nextState = S_EXEC;
          OP_LW,
          OP_SW:    w_nextState = S_MEMADR;
          OP_BEQ:   w_nextState = S_BRANCH;
          OP_ADDI:  w_nextState = S_ADDIEX;
          OP_J: begin
            if (SUPPORT_J != 0) begin
              w_nextState = S_JUMP;
            end else begin
              w_nextState  = S_TRAP;
              w_setIllegal = 1'b1;
            end
          end
          default: begin
            w_nextState  = S_TRAP;
            w_setIllegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_nextState = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_go) w_nextState = S_MEMWB;
      S_MEMWB:  w_nextState = S_FETCH;
      S_MEMWR:  if (w_go) w_nextState = S_FETCH;
      S_EXEC:   w_nextState = S_RWB;
      S_RWB:    w_nextState = S_FETCH;
      S_BRANCH: w_nextState = S_FETCH;
      S_ADDIEX: w_nextState = S_ADDIWB;
      S_ADDIWB: w_nextState = S_FETCH;
      S_JUMP:   w_nextState = S_FETCH;
      S_TRAP:   w_nextState = S_TRAP;
      default: begin
        w_nextState  = S_TRAP;
        w_setIllegal = 1'b1;
      end
    endcase
    if (w_timeoutHit) begin
      w_nextState  = S_TRAP;
      w_setTimeout = 1'b1;
    end
  end

  // State register, wait counter and sticky flags; reset restarts at FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_waitCnt    <= 8'd0;
      r_illegalOp  <= 1'b0;
      r_memTimeout <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state) begin
        r_waitCnt <= 8'd0;
      end else if (w_memWait) begin
        r_waitCnt <= r_waitCnt + 8'd1;
      end
      if (w_setIllegal) r_illegalOp  <= 1'b1;
      if (w_setTimeout) r_memTimeout <= 1'b1;
    end
  end

  // Moore output decode from the registered state; everything is held at 0 while in reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = r_illegalOp;
    mem_timeout   = r_memTimeout;
    state         = r_state;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = w_go;
        pc_write  = w_go;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      mem_timeout   = 1'b0;
      state         = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_cu.sv
// Testbench for multicycle_cu: three instances with different parameter sets
// are exercised one at a time against an instruction-level reference model.
module tb_multicycle_cu;

  // Control bundle in a fixed bit order so a whole cycle compares in one go.
  typedef struct packed {
    logic       pcW;
    logic       pcWC;
    logic       iOrD;
    logic       memRd;
    logic       memWr;
    logic       irW;
    logic       memToReg;
    logic       regDst;
    logic       regWr;
    logic       srcA;
    logic [1:0] srcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
  } ctl_t;

  logic            clk = 1'b0;
  logic [2:0]      rstN = 3'b000;
  logic [2:0]      rdy = 3'b000;
  logic [2:0][5:0] opc = '0;
  wire [2:0][15:0] obsCtl;
  wire [2:0][3:0]  obsState;
  wire [2:0]       obsIll;
  wire [2:0]       obsTo;
  int              total = 0;
  int              bad = 0;

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Instance 0: defaults; instance 1: timeout of 4 and no jump; instance 2: no memory wait.
  for (genvar g = 0; g < 3; g++) begin : gDut
    logic       pcW, pcWC, iOrD, memRd, memWr, irW, memToReg, regDst, regWr, srcA;
    logic [1:0] srcB, aluOp, pcSrc;
    multicycle_cu #(
      .MEM_WAIT_EN((g == 2) ? 0 : 1),
      .MEM_TIMEOUT((g == 1) ? 4 : 0),
      .SUPPORT_J  ((g == 1) ? 0 : 1)
    ) uDut (
      .clk          (clk),
      .rst_n        (rstN[g]),
      .opcode       (opc[g]),
      .mem_ready    (rdy[g]),
      .pc_write     (pcW),
      .pc_write_cond(pcWC),
      .i_or_d       (iOrD),
      .mem_read     (memRd),
      .mem_write    (memWr),
      .ir_write     (irW),
      .mem_to_reg   (memToReg),
      .reg_dst      (regDst),
      .reg_write    (regWr),
      .alu_src_a    (srcA),
      .alu_src_b    (srcB),
      .alu_op       (aluOp),
      .pc_source    (pcSrc),
      .illegal_op   (obsIll[g]),
      .mem_timeout  (obsTo[g]),
      .state        (obsState[g])
    );
    assign obsCtl[g] = {pcW, pcWC, iOrD, memRd, memWr, irW, memToReg, regDst, regWr,
                        srcA, srcB, aluOp, pcSrc};
  end

  function automatic bit waitEn(input int d);
    return d != 2;
  endfunction

  function automatic int tmo(input int d);
    return (d == 1) ? 4 : 0;
  endfunction

  function automatic bit supJ(input int d);
    return d != 1;
  endfunction

  // Instance 2 has mem_ready tied low; the others see random values.
  function automatic logic rndRdy(input int d);
    return waitEn(d) ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // Expected control strobes for a given state number, from the state table.
  function automatic ctl_t expCtl(input int s, input logic go);
    ctl_t c;
    c = '0;
    case (s)
      0:  begin c.memRd = 1'b1; c.srcB = 2'b01; c.irW = go; c.pcW = go; end
      1:  c.srcB = 2'b11;
      2:  begin c.srcA = 1'b1; c.srcB = 2'b10; end
      3:  begin c.memRd = 1'b1; c.iOrD = 1'b1; end
      4:  begin c.memToReg = 1'b1; c.regWr = 1'b1; end
      5:  begin c.memWr = 1'b1; c.iOrD = 1'b1; end
      6:  begin c.srcA = 1'b1; c.aluOp = 2'b10; end
      7:  begin c.regDst = 1'b1; c.regWr = 1'b1; end
      8:  begin c.srcA = 1'b1; c.aluOp = 2'b01; c.pcWC = 1'b1; c.pcSrc = 2'b01; end
      9:  begin c.srcA = 1'b1; c.srcB = 2'b10; end
      10: c.regWr = 1'b1;
      11: begin c.pcW = 1'b1; c.pcSrc = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // One clock cycle: drive mem_ready, sample on the falling edge, compare, move past the next rising edge.
  task automatic checkOutput(input int d, input int s, input logic r, input logic ill,
                             input logic to, input bit inReset, input string tag);
    ctl_t expC;
    rdy[d] = r;
    @(negedge clk);
    expC = inReset ? ctl_t'('0) : expCtl(s, r || !waitEn(d));
    total++;
    assert (obsState[d] === 4'(s)) else begin
      bad++;
      $error("[TB] FAIL %s.state dut=%0d got=%0d want=%0d", tag, d, obsState[d], s);
    end
    total++;
    assert (obsCtl[d] === expC) else begin
      bad++;
      $error("[TB] FAIL %s.ctl dut=%0d state=%0d got=%h want=%h", tag, d, s, obsCtl[d], expC);
    end
    total++;
    assert (obsIll[d] === ill) else begin
      bad++;
      $error("[TB] FAIL %s.illegal_op dut=%0d got=%b want=%b", tag, d, obsIll[d], ill);
    end
    total++;
    assert (obsTo[d] === to) else begin
      bad++;
      $error("[TB] FAIL %s.mem_timeout dut=%0d got=%b want=%b", tag, d, obsTo[d], to);
    end
    @(posedge clk);
    #1;
  endtask

  // Hold one instance in reset for n cycles (outputs must read 0), then release it.
  task automatic applyReset(input int d, input int n);
    rstN[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      opc[d] = 6'($urandom_range(0, 63));
      checkOutput(d, 0, rndRdy(d), 1'b0, 1'b0, 1'b1, "reset");
    end
    rstN[d] = 1'b1;
  endtask

  // Reference model for one instruction: the opcode picks the list of phases,
  // each memory phase is stretched by its not-ready cycles, and a stall of
  // MEM_TIMEOUT cycles or an illegal opcode ends in a held trap.
  task automatic applyStimulus(input int d, input logic [5:0] op, input int fw, input int mw,
                               input int hold, input string tag, output bit trapped);
    int seq[5];
    int len;
    trapped = 1'b0;
    opc[d] = op;
    seq = '{0, 1, 15, 0, 0};
    len = 3;
    case (op)
      6'b000000: begin seq = '{0, 1, 6, 7, 0};  len = 4; end
      6'b100011: begin seq = '{0, 1, 2, 3, 4};  len = 5; end
      6'b101011: begin seq = '{0, 1, 2, 5, 0};  len = 4; end
      6'b000100: begin seq = '{0, 1, 8, 0, 0};  len = 3; end
      6'b001000: begin seq = '{0, 1, 9, 10, 0}; len = 4; end
      6'b000010: if (supJ(d)) begin seq = '{0, 1, 11, 0, 0}; len = 3; end
      default: ;
    endcase
    for (int i = 0; i < len && !trapped; i++) begin
      if (seq[i] == 15) begin
        for (int k = 0; k < hold; k++) checkOutput(d, 15, rndRdy(d), 1'b1, 1'b0, 1'b0, tag);
        trapped = 1'b1;
      end else if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) begin
        int n;
        n = (seq[i] == 0) ? fw : mw;
        if (!waitEn(d)) begin
          checkOutput(d, seq[i], 1'b0, 1'b0, 1'b0, 1'b0, tag);
        end else begin
          for (int k = 0; k <= n && !trapped; k++) begin
            checkOutput(d, seq[i], 1'(k == n), 1'b0, 1'b0, 1'b0, tag);
            if (k != n && tmo(d) > 0 && k == tmo(d) - 1) begin
              for (int j = 0; j < hold; j++) checkOutput(d, 15, rndRdy(d), 1'b0, 1'b1, 1'b0, tag);
              trapped = 1'b1;
            end
          end
        end
      end else begin
        checkOutput(d, seq[i], rndRdy(d), 1'b0, 1'b0, 1'b0, tag);
      end
    end
  endtask

  // Directed steps per instance followed by a burst of random instructions.
  initial begin
    bit         tr;
    logic [5:0] op;
    logic [5:0] ops[6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    @(posedge clk);
    #1;

    $display("[TB] instance 0: default parameters");
    applyReset(0, 2);
    applyStimulus(0, 6'b000000, 0, 0, 3, "A.rtype", tr);
    applyStimulus(0, 6'b100011, 0, 2, 3, "A.lw2wait", tr);
    applyStimulus(0, 6'b101011, 0, 0, 3, "A.sw", tr);
    applyStimulus(0, 6'b000100, 0, 0, 3, "A.beq", tr);
    applyStimulus(0, 6'b000010, 0, 0, 3, "A.jump", tr);
    applyStimulus(0, 6'b001000, 1, 0, 3, "A.addi", tr);
    applyStimulus(0, 6'b101011, 2, 3, 3, "A.swWait", tr);
    for (int i = 0; i < 20; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)];
      applyStimulus(0, op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 3, "A.rand", tr);
      if (tr) applyReset(0, 1);
    end
    opc[0] = 6'b100011;
    checkOutput(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "A.abort");
    checkOutput(0, 1, 1'b0, 1'b0, 1'b0, 1'b0, "A.abort");
    checkOutput(0, 2, 1'b0, 1'b0, 1'b0, 1'b0, "A.abort");
    applyReset(0, 1);
    applyStimulus(0, 6'b000000, 0, 0, 3, "A.afterAbort", tr);
    applyStimulus(0, 6'b111111, 0, 0, 5, "A.illegal", tr);
    applyReset(0, 1);
    applyStimulus(0, 6'b000100, 0, 0, 3, "A.afterTrap", tr);
    rstN[0] = 1'b0;

    $display("[TB] instance 1: timeout 4, no jump");
    applyReset(1, 2);
    applyStimulus(1, 6'b000010, 0, 0, 20, "B.jTrap", tr);
    applyReset(1, 1);
    applyStimulus(1, 6'b000000, 4, 0, 3, "B.fetchTimeout", tr);
    applyReset(1, 1);
    applyStimulus(1, 6'b000000, 3, 0, 3, "B.fetchLastCycle", tr);
    applyStimulus(1, 6'b100011, 0, 4, 3, "B.lwTimeout", tr);
    applyReset(1, 1);
    applyStimulus(1, 6'b100011, 0, 3, 3, "B.lwLastCycle", tr);
    applyStimulus(1, 6'b101011, 0, 4, 3, "B.swTimeout", tr);
    applyReset(1, 1);
    for (int i = 0; i < 16; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 4)];
      applyStimulus(1, op, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 2, "B.rand", tr);
      if (tr) applyReset(1, 1);
    end
    rstN[1] = 1'b0;

    $display("[TB] instance 2: memory wait disabled, mem_ready tied low");
    applyReset(2, 2);
    applyStimulus(2, 6'b100011, 9, 9, 3, "C.lwNoWait", tr);
    applyStimulus(2, 6'b101011, 9, 9, 3, "C.swNoWait", tr);
    for (int i = 0; i < 12; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)];
      applyStimulus(2, op, 5, 5, 2, "C.rand", tr);
      if (tr) applyReset(2, 1);
    end
    applyStimulus(2, 6'b111111, 0, 0, 4, "C.illegal", tr);
    applyReset(2, 1);
    applyStimulus(2, 6'b000000, 0, 0, 3, "C.afterTrap", tr);
    rstN[2] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Multi-cycle main control unit for the MIPS datapath: a Moore FSM that sequences each instruction over 3–5 states instead of decoding it in one combinational step.
- Supports R-type, LW, SW, BEQ, ADDI and optional J.
- Adds a memory-ready handshake, an optional memory-wait timeout, and a sticky trap on illegal opcodes.
- Sits between the instruction register (opcode field) and the shared datapath: PC, memory, register file, ALU and its control.

Parameters:
- MEM_WAIT_EN, 1, 1: memory states wait for mem_ready; 0: memory always completes in one cycle and mem_ready is ignored.
- MEM_TIMEOUT, 0, number of consecutive not-ready cycles in one memory state before trapping; 0 disables the timeout. Range 0..255.
- SUPPORT_J, 1, 1: opcode 000010 decodes as a jump; 0: it traps as illegal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- opcode  input  6  IR[31:26]; stable from DECODE until return to FETCH (IR written only in FETCH)
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by ALU zero (BEQ)
- i_or_d  output  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  register write data: 1 = MDR, 0 = ALUOut
- reg_dst  output  1  1 = rd, 0 = rt
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  sticky illegal-opcode flag
- mem_timeout  output  1  sticky memory-timeout flag
- state  output  4  current state encoding, for debug

Behaviour:
- go = mem_ready | (MEM_WAIT_EN==0).
- All outputs are decoded from the registered state only, except ir_write/pc_write in FETCH, which are gated by go.
- Any signal not listed for a state is 0.
- Reset: while rst_n==0 all control outputs are forced to 0 and state shows 0. The next rising edge loads FETCH and clears wait_cnt, illegal_op and mem_timeout.
- Reset mid-instruction aborts the instruction; no partial strobes are issued after the reset edge.
- States, as encoding: outputs -> next state:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=go -> DECODE if go, else stay.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 -> next state by opcode: 000000 EXEC; 100011/101011 MEMADR; 000100 BRANCH; 001000 ADDIEX; 000010 JUMP if SUPPORT_J, else TRAP; any other opcode TRAP.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00 -> MEMRD if opcode==100011, else MEMWR.
  - MEMRD(3): mem_read=1, i_or_d=1 -> MEMWB on go, else stay.
  - MEMWB(4): mem_to_reg=1, reg_write=1, reg_dst=0 -> FETCH.
  - MEMWR(5): mem_write=1, i_or_d=1 -> FETCH on go, else stay.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10 -> RWB.
  - RWB(7): reg_dst=1, reg_write=1 -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
  - ADDIEX(9): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
  - ADDIWB(10): reg_write=1, reg_dst=0 -> FETCH.
  - JUMP(11): pc_write=1, pc_source=10 -> FETCH.
  - TRAP(15): all strobes 0 -> stays in TRAP until reset.
  - Encodings 12–14 are unused and go to TRAP with illegal_op set.
- Sticky flags: illegal_op is set on entry to TRAP from DECODE. mem_timeout is set on entry to TRAP via timeout.
- Timeout counter wait_cnt (8 bits):
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with go==0.
  - Clears on any state change.
  - If MEM_TIMEOUT>0 and wait_cnt==MEM_TIMEOUT-1 while go==0, the next state is TRAP.
  - If mem_ready arrives in that same cycle, completion wins and no trap occurs.
- Latency with zero wait states: R/ADDI 4 cycles, LW 5, SW 4, BEQ/J 3.
- Each wait cycle adds exactly 1 cycle.

Test Plan:
- Reset, then R-type: rst_n=0 for 2 cycles, then opcode=000000, mem_ready=1 -> all outputs 0 during reset; state sequence 0,1,6,7,0; reg_dst=reg_write=1 only in state 7; alu_op=10 in state 6.
- LW with 2 wait states: opcode=100011, mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; mem_read=i_or_d=1 for all 3 MEMRD cycles; mem_to_reg=reg_write=1 in state 4.
- SW, then BEQ back-to-back with mem_ready=1 -> SW states 0,1,2,5,0 with mem_write=1 only in 5; BEQ states 0,1,8,0 with pc_write_cond=1, pc_source=01, alu_op=01.
- Jump gating: opcode=000010 with SUPPORT_J=1 -> states 0,1,11,0, pc_write=1, pc_source=10. With SUPPORT_J=0 -> state 15, illegal_op=1, held for 20 cycles; a reset pulse returns to state 0 and clears the flag.
- Timeout: MEM_TIMEOUT=4, mem_ready=0 in FETCH -> 4 cycles in state 0, then state 15, mem_timeout=1, illegal_op=0. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no trap.
- Illegal opcode 111111 and MEM_WAIT_EN=0 with mem_ready tied 0 -> opcode 111111 traps with illegal_op=1; with MEM_WAIT_EN=0, LW completes in 5 cycles despite mem_ready=0.
